// File: rtl/jt51_wrqueue.sv
// jt51_wrqueue: CPU-side write buffer in front of jt51_mmr.
// Stores address/data writes in order and replays them as 1-clk strobes,
// waiting out jt51_mmr's busy window so the CPU never needs to poll.
module jt51_wrqueue #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_wr,
    input  logic          cpu_a0,
    input  logic [7:0]    cpu_din,
    output logic          full,
    output logic          pend,
    output logic          ovf,
    output logic [AW:0]   level,
    output logic          mmr_write,
    output logic          mmr_a0,
    output logic [7:0]    mmr_din,
    input  logic          mmr_busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        GAP   = 2'd2,
        WAITB = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            mmr_write_q, mmr_write_d;
    logic            mmr_a0_q, mmr_a0_d;
    logic [7:0]      mmr_din_q, mmr_din_d;
    logic            ovf_q, ovf_d;
    logic [8:0]      mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic [8:0]      head;

    // Queue bookkeeping and replay FSM next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mmr_write_d = mmr_write_q;
        mmr_a0_d    = mmr_a0_q;
        mmr_din_d   = mmr_din_q;
        ovf_d       = ovf_q;
        head        = mem_q[rd_ptr_q];

        // full comes from the registered level, so a same-cycle pop never frees room.
        push = cpu_wr && !full;
        pop  = (state_q == IDLE) && (level_q != '0);

        if (cpu_wr && full) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    mmr_a0_d    = head[8];
                    mmr_din_d   = head[7:0];
                    mmr_write_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    state_d     = WR;
                end
            end
            WR: begin
                mmr_write_d = 1'b0;
                state_d     = GAP;
            end
            GAP: begin
                // One low cycle guarantees a fresh rising edge for the next strobe.
                state_d = WAITB;
            end
            WAITB: begin
                if (!mmr_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mmr_write_q <= 1'b0;
            mmr_a0_q    <= 1'b0;
            mmr_din_q   <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mmr_write_q <= mmr_write_d;
            mmr_a0_q    <= mmr_a0_d;
            mmr_din_q   <= mmr_din_d;
            ovf_q       <= ovf_d;
        end
    end

    // Entry storage, written on accepted pushes.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; level and pointers alone define which entries are valid.
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {cpu_a0, cpu_din};
        end
    end

    assign full      = (level_q == (AW+1)'(DEPTH));
    assign pend      = (level_q != '0) || (state_q != IDLE) || mmr_busy;
    assign ovf       = ovf_q;
    assign level     = level_q;
    assign mmr_write = mmr_write_q;
    assign mmr_a0    = mmr_a0_q;
    assign mmr_din   = mmr_din_q;

endmodule

// File: tb/tb_jt51_wrqueue.sv
// Self-checking bench for jt51_wrqueue: cycle vector table plus directed
// corner-case sequences and a randomised stream against a scoreboard.
module tb_jt51_wrqueue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_wr;
    logic       cpu_a0;
    logic [7:0] cpu_din;
    logic       full;
    logic       pend;
    logic       ovf;
    logic [3:0] level;
    logic       mmr_write;
    logic       mmr_a0;
    logic [7:0] mmr_din;
    logic       mmr_busy;

    logic       busy_ovr;
    logic       model_en;
    logic [5:0] busy_cnt;
    logic       mon_chk;
    logic       prev_write;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    jt51_wrqueue #(.AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_wr    (cpu_wr),
        .cpu_a0    (cpu_a0),
        .cpu_din   (cpu_din),
        .full      (full),
        .pend      (pend),
        .ovf       (ovf),
        .level     (level),
        .mmr_write (mmr_write),
        .mmr_a0    (mmr_a0),
        .mmr_din   (mmr_din),
        .mmr_busy  (mmr_busy)
    );

    // Simple jt51_mmr busy model: 32 clk of busy after each data strobe.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 6'd0;
        else if (mmr_write && mmr_a0) busy_cnt <= 6'd32;
        else if (busy_cnt != 6'd0) busy_cnt <= busy_cnt - 6'd1;
    end

    assign mmr_busy = busy_ovr | (model_en & (busy_cnt != 6'd0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe monitor: records every write seen by jt51_mmr.
    always @(posedge clk) begin
        if (mmr_write) begin
            got_q.push_back({mmr_a0, mmr_din});
            if (mon_chk) begin
                check("strobe_while_busy", {31'd0, mmr_busy}, 32'd0);
                check("strobe_two_clk", {31'd0, prev_write}, 32'd0);
            end
        end
        prev_write <= mmr_write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_wr = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_write", {31'd0, mmr_write}, 32'd0);
        check("rst_a0", {31'd0, mmr_a0}, 32'd0);
        check("rst_din", {24'd0, mmr_din}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_pend", {31'd0, pend}, {31'd0, mmr_busy});
    endtask

    task automatic push1(input logic a0, input logic [7:0] d);
        cpu_wr = 1'b1;
        cpu_a0 = a0;
        cpu_din = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string nm);
        for (int i = 0; i < max && pend; i++) tick();
        check(nm, {31'd0, pend}, 32'd0);
    endtask

    task automatic compare_streams(input string nm);
        check({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({nm, "_entry"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    endtask

    typedef struct {
        logic       wr;
        logic       a0;
        logic [7:0] din;
        logic       busy;
        logic       e_write;
        logic       e_a0;
        logic [7:0] e_din;
        logic [3:0] e_level;
        logic       e_full;
        logic       e_pend;
    } vec_t;

    vec_t vt[20];

    initial begin
        // inputs (wr a0 din busy) | expected after the edge (write a0 din level full pend)
        vt[0]  = '{1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 4'd0, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 4'd0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 4'd0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 4'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 8'h28, 1'b0, 1'b0, 1'b0, 8'h20, 4'd1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 8'h4A, 1'b0, 1'b1, 1'b0, 8'h28, 4'd1, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h28, 4'd1, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h28, 4'd1, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h28, 4'd1, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h4A, 4'd0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h4A, 4'd0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h4A, 4'd0, 1'b0, 1'b1};
        vt[13] = '{1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b1, 8'h4A, 4'd1, 1'b0, 1'b1};
        vt[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h4A, 4'd1, 1'b0, 1'b1};
        vt[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h4A, 4'd1, 1'b0, 1'b1};
        vt[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h30, 4'd0, 1'b0, 1'b1};
        vt[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h30, 4'd0, 1'b0, 1'b1};
        vt[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h30, 4'd0, 1'b0, 1'b1};
        vt[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h30, 4'd0, 1'b0, 1'b0};

        rst = 1'b0;
        cpu_wr = 1'b0;
        cpu_a0 = 1'b0;
        cpu_din = 8'h00;
        busy_ovr = 1'b0;
        model_en = 1'b0;
        mon_chk = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single write latency, address/data pair spacing, WAITB on busy.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cpu_wr   = vt[i].wr;
            cpu_a0   = vt[i].a0;
            cpu_din  = vt[i].din;
            busy_ovr = vt[i].busy;
            tick();
            check($sformatf("vec%0d_write", i), {31'd0, mmr_write}, {31'd0, vt[i].e_write});
            check($sformatf("vec%0d_a0", i), {31'd0, mmr_a0}, {31'd0, vt[i].e_a0});
            check($sformatf("vec%0d_din", i), {24'd0, mmr_din}, {24'd0, vt[i].e_din});
            check($sformatf("vec%0d_level", i), {28'd0, level}, {28'd0, vt[i].e_level});
            check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vt[i].e_full});
            check($sformatf("vec%0d_pend", i), {31'd0, pend}, {31'd0, vt[i].e_pend});
        end
        cpu_wr = 1'b0;
        busy_ovr = 1'b0;

        // Fill past capacity while the FSM is parked in WAITB.
        do_reset();
        busy_ovr = 1'b1;
        push1(1'b1, 8'hFF);
        repeat (4) tick();
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back({k[0], 8'h10 + 8'(k)});
            push1(k[0], 8'h10 + 8'(k));
        end
        check("fill_level", {28'd0, level}, 32'd8);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_ovf", {31'd0, ovf}, 32'd1);
        busy_ovr = 1'b0;
        model_en = 1'b1;
        wait_idle(1000, "fill_drain_timeout");
        compare_streams("fill_order");
        model_en = 1'b0;

        // Push into a full queue on the very cycle IDLE pops.
        do_reset();
        busy_ovr = 1'b1;
        push1(1'b0, 8'h01);
        repeat (4) tick();
        for (int k = 0; k < 8; k++) push1(1'b0, 8'h50 + 8'(k));
        check("popfull_level8", {28'd0, level}, 32'd8);
        check("popfull_ovf0", {31'd0, ovf}, 32'd0);
        busy_ovr = 1'b0;
        tick();
        check("popfull_idle_level", {28'd0, level}, 32'd8);
        cpu_wr = 1'b1;
        cpu_a0 = 1'b1;
        cpu_din = 8'hEE;
        tick();
        cpu_wr = 1'b0;
        check("popfull_level7", {28'd0, level}, 32'd7);
        check("popfull_ovf1", {31'd0, ovf}, 32'd1);
        check("popfull_full0", {31'd0, full}, 32'd0);
        check("popfull_strobe", {31'd0, mmr_write}, 32'd1);
        check("popfull_din", {24'd0, mmr_din}, 32'h50);

        // Reset during WAITB with entries still queued aborts everything.
        busy_ovr = 1'b1;
        repeat (3) tick();
        check("abort_pre_level", {28'd0, level}, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_level", {28'd0, level}, 32'd0);
        check("abort_write", {31'd0, mmr_write}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        check("abort_full", {31'd0, full}, 32'd0);
        check("abort_pend_busy", {31'd0, pend}, 32'd1);
        got_q.delete();
        busy_ovr = 1'b0;
        repeat (60) tick();
        check("abort_no_strobes", got_q.size(), 32'd0);
        check("abort_pend_idle", {31'd0, pend}, 32'd0);

        // Random stream against a scoreboard with the busy model attached.
        do_reset();
        model_en = 1'b1;
        mon_chk = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 5)) tick();
            cpu_wr = 1'b1;
            cpu_a0 = 1'($urandom_range(0, 1));
            cpu_din = 8'($urandom_range(0, 255));
            if (!full) exp_q.push_back({cpu_a0, cpu_din});
            tick();
            cpu_wr = 1'b0;
        end
        wait_idle(20000, "rand_drain_timeout");
        mon_chk = 1'b0;
        compare_streams("rand_order");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
